// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: drives one column low at a time, debounces
// presses and releases, and hands accepted key codes to a consumer.
module keypad_scanner #(
  parameter int SETTLE_CYCLES   = 16,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] rows_n,
  output logic [3:0] col_n,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ack,
  output logic       key_held,
  output logic       overrun
);

  localparam int SW = $clog2(SETTLE_CYCLES);
  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [SW-1:0] SETTLE_LAST   = SW'(SETTLE_CYCLES - 1);
  localparam logic [DW-1:0] DEBOUNCE_LAST = DW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    PRESSED,
    RELEASE
  } state_e;

  state_e        state_q;
  logic [1:0]    col_q;
  logic [3:0]    col_n_q;
  logic [SW-1:0] settle_q;
  logic [DW-1:0] deb_q;
  logic [3:0]    pattern_q;
  logic [3:0]    rows_meta_q;
  logic [3:0]    rows_s_q;
  logic [3:0]    key_code_q;
  logic          key_valid_q;
  logic          key_held_q;
  logic          overrun_q;

  // Lowest-index closed row wins when several keys share the column.
  function automatic logic [1:0] first_low(input logic [3:0] p);
    if (!p[0])      return 2'd0;
    else if (!p[1]) return 2'd1;
    else if (!p[2]) return 2'd2;
    else            return 2'd3;
  endfunction

  function automatic logic [3:0] col_strobe(input logic [1:0] c);
    return ~(4'b0001 << c);
  endfunction

  // Rows are released to the pull-ups when idle, so the synchronizer resets high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rows_meta_q <= 4'hF;
      rows_s_q    <= 4'hF;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the pre-edge
      // value, so the two stages really are two clocks apart.
      rows_meta_q <= rows_n;
      rows_s_q    <= rows_meta_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= SCAN;
      col_q       <= 2'd0;
      col_n_q     <= 4'b1110;
      settle_q    <= '0;
      deb_q       <= '0;
      pattern_q   <= 4'hF;
      key_code_q  <= 4'd0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      // NOTE: the acknowledge clear is written first so that an acceptance
      // in the same cycle, assigned later below, takes precedence.
      if (key_ack && key_valid_q) key_valid_q <= 1'b0;

      unique case (state_q)
        SCAN: begin
          if (settle_q == SETTLE_LAST) begin
            settle_q <= '0;
            if (&rows_s_q) begin
              col_q   <= col_q + 2'd1;
              col_n_q <= col_strobe(col_q + 2'd1);
            end else begin
              pattern_q <= rows_s_q;
              deb_q     <= '0;
              state_q   <= DEBOUNCE;
            end
          end else begin
            settle_q <= settle_q + SW'(1);
          end
        end

        DEBOUNCE: begin
          if (rows_s_q != pattern_q) begin
            state_q  <= SCAN;
            settle_q <= '0;
          end else if (deb_q == DEBOUNCE_LAST) begin
            state_q    <= PRESSED;
            key_held_q <= 1'b1;
            if (!key_valid_q || key_ack) begin
              key_code_q  <= {col_q, first_low(pattern_q)};
              key_valid_q <= 1'b1;
            end else begin
              overrun_q <= 1'b1;
            end
          end else begin
            deb_q <= deb_q + DW'(1);
          end
        end

        PRESSED: begin
          if (&rows_s_q) begin
            state_q <= RELEASE;
            deb_q   <= '0;
          end
        end

        RELEASE: begin
          if (!(&rows_s_q)) begin
            state_q <= PRESSED;
          end else if (deb_q == DEBOUNCE_LAST) begin
            state_q    <= SCAN;
            settle_q   <= '0;
            col_q      <= col_q + 2'd1;
            col_n_q    <= col_strobe(col_q + 2'd1);
            key_held_q <= 1'b0;
          end else begin
            deb_q <= deb_q + DW'(1);
          end
        end

        default: state_q <= SCAN;
      endcase
    end
  end

  assign col_n     = col_n_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;
  assign overrun   = overrun_q;

endmodule
